// File: rtl/nibble_serial_adder.sv
// Serial adder/subtractor: one 4-bit nibble per clock, LSB nibble first, with valid/ready on both sides.
// Optional macro NSA_OVF_EN adds the signed-overflow output ovf.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef NSA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIBS = WIDTH / 4;
  localparam int CW   = $clog2(NIBS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             carry;
  logic [4:0]       nib_sum;
  logic             last_nib;
  logic             in_fire;

  assign nib_sum  = {1'b0, a_reg[3:0]} + {1'b0, b_reg[3:0]} + {4'b0, carry};
  assign last_nib = (cnt == CW'(NIBS - 1));
  assign in_fire  = in_valid && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_nib) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // s/cout live apart from the working carry so the last result survives the next capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
    end else if (in_fire) begin
      cnt   <= '0;
      a_reg <= a;
      b_reg <= b ^ {WIDTH{sub}};
      carry <= sub | cin;
    end else if (state == RUN) begin
      s     <= {nib_sum[3:0], s[WIDTH-1:4]};
      a_reg <= {4'b0, a_reg[WIDTH-1:4]};
      b_reg <= {4'b0, b_reg[WIDTH-1:4]};
      carry <= nib_sum[4];
      cout  <= nib_sum[4];
      if (!last_nib) cnt <= cnt + 1'b1;
    end
  end

`ifdef NSA_OVF_EN
  logic [3:0] low_sum;

  // carry into the nibble's top bit; the last RUN cycle leaves the top nibble's value
  assign low_sum = {1'b0, a_reg[2:0]} + {1'b0, b_reg[2:0]} + {3'b0, carry};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              ovf <= 1'b0;
    else if (state == RUN)   ovf <= low_sum[3] ^ nib_sum[4];
  end
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): directed vectors, reset abort,
// output hold, randomized requests and back-to-back throughput against an arithmetic model.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        cout;
`ifdef NSA_OVF_EN
  logic        ovf;
`endif

  int errors = 0;
  int checks = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout)
`ifdef NSA_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference: {ovf, cout, s} from plain two's-complement arithmetic
  function automatic logic [17:0] model(input logic [15:0] ta, input logic [15:0] tb,
                                        input logic tcin, input logic tsub);
    logic [15:0] bb;
    logic [16:0] t;
    logic        o;
    bb = tsub ? ~tb : tb;
    t  = {1'b0, ta} + {1'b0, bb} + {16'b0, (tsub ? 1'b1 : tcin)};
    o  = (ta[15] == bb[15]) && (t[15] != ta[15]);
    return {o, t};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handshake one request and wait (bounded) for out_valid; handshake edge counts as edge 1
  task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb,
                               input logic tcin, input logic tsub);
    int lat;
    checkOutput("in_ready_idle", in_ready, 1);
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    lat = 1;
    checkOutput("in_ready_run", in_ready, 0);
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", lat, 5);
  endtask

  task automatic checkResult(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                             input logic tcin, input logic tsub);
    logic [17:0] exp;
    exp = model(ta, tb, tcin, tsub);
    checkOutput({tag, "_s"}, s, exp[15:0]);
    checkOutput({tag, "_cout"}, cout, exp[16]);
`ifdef NSA_OVF_EN
    checkOutput({tag, "_ovf"}, ovf, exp[17]);
`endif
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("release_valid", out_valid, 0);
    checkOutput("release_ready", in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] ta, tb;
    logic        tcin, tsub;
    logic [17:0] exp;
    logic        sawValid;
    logic [15:0] qa[$], qb[$];
    logic        qc[$], qs[$];
    logic        fired;
    int          lastOut, nres;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #2;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_s", s, 0);
    checkOutput("rst_cout", cout, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed vectors, including the first request straight out of reset
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    checkResult("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    checkOutput("wrap_s_const", s, 16'h0000);
    releaseResult();
    applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1);
    checkResult("borrow", 16'h0005, 16'h0007, 1'b0, 1'b1);
    checkOutput("borrow_s_const", s, 16'hFFFE);
    releaseResult();
    applyStimulus(16'h1234, 16'h1234, 1'b1, 1'b1);
    checkResult("equal", 16'h1234, 16'h1234, 1'b1, 1'b1);
    releaseResult();
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    checkResult("posovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    releaseResult();
    applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1);
    checkResult("negovf", 16'h8000, 16'h0001, 1'b0, 1'b1);
    releaseResult();

    // Result retained in IDLE while inputs wander
    repeat (3) begin
      a = 16'($urandom); b = 16'($urandom);
      @(posedge clk); #1;
    end
    checkOutput("idle_keep_s", s, 16'h7FFF);
    checkOutput("idle_keep_cout", cout, 1);

    // Hold in DONE with out_ready low and in_valid high; no accept on release edge
    applyStimulus(16'h1234, 16'h0FED, 1'b1, 1'b0);
    exp = model(16'h1234, 16'h0FED, 1'b1, 1'b0);
    in_valid = 1'b1;
    repeat (10) begin
      a = 16'($urandom); b = 16'($urandom);
      @(posedge clk); #1;
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_in_ready", in_ready, 0);
      checkOutput("hold_s", s, exp[15:0]);
      checkOutput("hold_cout", cout, exp[16]);
    end
    releaseResult();
    in_valid = 1'b0;
    checkOutput("hold_after_s", s, exp[15:0]);

    // Reset during RUN aborts the operation
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checkOutput("abort_s", s, 0);
    checkOutput("abort_cout", cout, 0);
    checkOutput("abort_in_ready", in_ready, 1);
    sawValid = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("abort_no_valid", sawValid, 0);
    rst_n = 1'b1;
    applyStimulus(16'h0003, 16'h0004, 1'b1, 1'b0);
    checkResult("post_abort", 16'h0003, 16'h0004, 1'b1, 1'b0);
    releaseResult();

    // Randomized requests with random downstream stall
    for (int i = 0; i < 20; i++) begin
      ta = 16'($urandom); tb = 16'($urandom); tcin = 1'($urandom); tsub = 1'($urandom);
      applyStimulus(ta, tb, tcin, tsub);
      checkResult("rand", ta, tb, tcin, tsub);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      releaseResult();
    end

    // Back-to-back: in_valid and out_ready held high
    in_valid = 1'b1; out_ready = 1'b1;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    lastOut = -1; nres = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      fired = in_valid && in_ready;
      if (fired) begin
        qa.push_back(a); qb.push_back(b); qc.push_back(cin); qs.push_back(sub);
      end
      if (out_valid && out_ready) begin
        checkOutput("b2b_pending", (qa.size() > 0), 1);
        if (qa.size() > 0) begin
          exp = model(qa[0], qb[0], qc[0], qs[0]);
          void'(qa.pop_front()); void'(qb.pop_front());
          void'(qc.pop_front()); void'(qs.pop_front());
          checkOutput("b2b_s", s, exp[15:0]);
          checkOutput("b2b_cout", cout, exp[16]);
        end
        if (lastOut >= 0) checkOutput("b2b_spacing", cyc - lastOut, 6);
        lastOut = cyc;
        nres++;
      end
      @(posedge clk); #1;
      if (fired) begin
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checkOutput("b2b_count", nres, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001: The block SHALL have parameter WIDTH, default 16, giving operand width in bits; legal values are multiples of 4, minimum 8.
REQ-002: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003: rst_n  input  1  reset, asynchronous and active-low.
REQ-004: in_valid  input  1  operand request valid.
REQ-005: in_ready  output  1  block can accept an operand request.
REQ-006: a  input  WIDTH  operand A, unsigned or two's complement.
REQ-007: b  input  WIDTH  operand B.
REQ-008: cin  input  1  carry-in, used only when sub=0.
REQ-009: sub  input  1  1 = compute a-b; 0 = compute a+b+cin.
REQ-010: out_valid  output  1  result valid.
REQ-011: out_ready  input  1  downstream accepts the result.
REQ-012: s  output  WIDTH  registered sum/difference.
REQ-013: cout  output  1  carry out of bit WIDTH-1.
REQ-014: ovf  output  1  signed overflow flag, present only when NSA_OVF_EN is defined.

Function
REQ-015: The block SHALL have states IDLE, RUN and DONE; reset enters IDLE.
REQ-016: in_ready SHALL equal 1 in IDLE and 0 in RUN and DONE.
REQ-017: An input handshake is in_valid=1 and in_ready=1 at a rising edge.
REQ-018: On an input handshake the block SHALL capture a, b XOR {WIDTH{sub}}, and initial carry (sub ? 1 : cin), then enter RUN with nibble counter = 0.
REQ-019: Each RUN cycle SHALL add the low nibble of the A/B shift registers plus the carry register.
REQ-020: Each RUN cycle SHALL shift the 4-bit result into the top of the sum register, shift the A/B registers right by 4, and load the carry register with the nibble carry-out.
REQ-021: The nibble counter SHALL run 0..WIDTH/4-1; on the last count the block SHALL enter DONE, with no wrap beyond WIDTH/4-1.
REQ-022: out_valid SHALL be 1 exactly in DONE; it rises WIDTH/4+1 edges after the input handshake edge (5 for WIDTH=16).
REQ-023: In DONE, s, cout and ovf SHALL hold stable until out_valid=1 and out_ready=1 at an edge; that edge returns the block to IDLE.
REQ-024: s/cout/ovf SHALL retain the last result in IDLE, and they change only during the RUN that follows the next input handshake.
REQ-025: cout SHALL be the final carry register value; for sub=1, cout=1 means no borrow (a>=b unsigned).
REQ-026: a, b, cin and sub SHALL be ignored outside an input handshake, and in_valid in RUN/DONE has no effect.
REQ-027: out_ready outside DONE SHALL have no effect.
REQ-028: The block SHALL NOT accept new input in the DONE state, even in the out-handshake cycle; the minimum request-to-request spacing is WIDTH/4+2 cycles.

Reset
REQ-029: When rst_n=0, the block SHALL immediately enter IDLE and clear the counter, carry register, A/B registers, s, cout and ovf to 0, with out_valid=0 and in_ready=1 while rst_n is low.
REQ-030: Reset asserted during RUN or DONE SHALL abort the operation with no result produced.
REQ-031: On the first edge after rst_n rises, the block SHALL accept an input handshake.

Configuration
REQ-032: With macro NSA_OVF_EN defined, port ovf SHALL exist and in DONE SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1 (the top nibble's internal bit-2 carry XOR its carry-out).
REQ-033: Without NSA_OVF_EN, port ovf and its logic SHALL be absent, and all other behaviour is identical.

Verification
REQ-034: WIDTH=16, a=0xFFFF b=0x0001 cin=0 sub=0 -> out_valid 5 edges after handshake, s=0x0000 cout=1 (ovf=0).
REQ-035: a=0x0005 b=0x0007 sub=1 -> s=0xFFFE cout=0; a=0x1234 b=0x1234 sub=1 -> s=0x0000 cout=1.
REQ-036: NSA_OVF_EN defined, a=0x7FFF b=0x0001 sub=0 -> s=0x8000 ovf=1 cout=0; a=0x8000 b=0x0001 sub=1 -> s=0x7FFF ovf=1.
REQ-037: out_ready held 0 for 10 cycles in DONE -> s/cout/out_valid stable and in_ready=0 throughout; the result is released on the first out_ready=1 edge.
REQ-038: rst_n pulsed low at RUN cycle 2 of a=0xAAAA b=0x5555 -> outputs zero, no out_valid, next request 0x0003+0x0004 cin=1 yields s=0x0008.
REQ-039: Back-to-back requests with in_valid held high and out_ready=1 -> one result every 6 cycles, in order, each numerically correct.
